// File: rtl/twd_trans_splitter_ipa_pkg.sv
// Shared definitions for the 2D transaction splitter (package mchan_twd_pkg_ipa).
//   - default width constants (the *_DEF names; modules take them as parameter defaults)
//   - twd_entry_t: one 2D parameter queue entry, stride in the MSBs and row_len in the LSBs
//   - split_state_e: the splitter FSM states
package mchan_twd_pkg_ipa;

  localparam int ADD_WIDTH_DEF           = 32;
  localparam int LEN_WIDTH_DEF           = 16;
  localparam int ROWLEN_WIDTH_DEF        = 16;
  localparam int STRIDE_WIDTH_DEF        = 16;
  localparam int TWD_QUEUE_ADD_WIDTH_DEF = 2;
  localparam int TWD_QUEUE_WIDTH_DEF     = STRIDE_WIDTH_DEF + ROWLEN_WIDTH_DEF;

  typedef struct packed {
    logic [STRIDE_WIDTH_DEF-1:0] stride;
    logic [ROWLEN_WIDTH_DEF-1:0] row_len;
  } twd_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_e;

endpackage

// File: rtl/twd_trans_splitter_ipa_if.sv
// Bus bundle for the 2D transaction splitter.
//   cmd_*  : command handshake (req/gnt) and command fields
//   twd_*  : read port into the 2D parameter queue (combinational read data)
//   out_*  : 1D row request handshake (req/gnt) and row fields
// Modports:
//   master : command source / queue / row consumer side
//   slave  : the splitter
interface twd_trans_splitter_ipa_if
  import mchan_twd_pkg_ipa::*;
#(
  parameter int ADD_WIDTH           = ADD_WIDTH_DEF,
  parameter int LEN_WIDTH           = LEN_WIDTH_DEF,
  parameter int TWD_QUEUE_ADD_WIDTH = TWD_QUEUE_ADD_WIDTH_DEF,
  parameter int TWD_QUEUE_WIDTH     = TWD_QUEUE_WIDTH_DEF
) ();

  logic                           cmd_req_i;
  logic                           cmd_gnt_o;
  logic [ADD_WIDTH-1:0]           cmd_ext_add_i;
  logic [ADD_WIDTH-1:0]           cmd_tcdm_add_i;
  logic [LEN_WIDTH-1:0]           cmd_len_i;
  logic                           cmd_opc_i;
  logic                           cmd_twd_i;
  logic [TWD_QUEUE_ADD_WIDTH-1:0] cmd_twd_add_i;

  logic                           twd_rd_req_o;
  logic [TWD_QUEUE_ADD_WIDTH-1:0] twd_rd_add_o;
  logic [TWD_QUEUE_WIDTH-1:0]     twd_rd_dat_i;

  logic                           out_req_o;
  logic                           out_gnt_i;
  logic [ADD_WIDTH-1:0]           out_ext_add_o;
  logic [ADD_WIDTH-1:0]           out_tcdm_add_o;
  logic [LEN_WIDTH-1:0]           out_len_o;
  logic                           out_opc_o;
  logic                           out_last_o;

  modport master (
    output cmd_req_i, cmd_ext_add_i, cmd_tcdm_add_i, cmd_len_i, cmd_opc_i, cmd_twd_i, cmd_twd_add_i,
    input  cmd_gnt_o,
    input  twd_rd_req_o, twd_rd_add_o,
    output twd_rd_dat_i,
    input  out_req_o, out_ext_add_o, out_tcdm_add_o, out_len_o, out_opc_o, out_last_o,
    output out_gnt_i
  );

  modport slave (
    input  cmd_req_i, cmd_ext_add_i, cmd_tcdm_add_i, cmd_len_i, cmd_opc_i, cmd_twd_i, cmd_twd_add_i,
    output cmd_gnt_o,
    output twd_rd_req_o, twd_rd_add_o,
    input  twd_rd_dat_i,
    output out_req_o, out_ext_add_o, out_tcdm_add_o, out_len_o, out_opc_o, out_last_o,
    input  out_gnt_i
  );

endinterface

// File: rtl/twd_trans_splitter_ipa.sv
// Splits one DMA command at a time into 1D row requests. 2D commands fetch
// {stride, row_len} from the parameter queue on acceptance (the read frees the
// slot); 1D commands become a single row.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : twd_trans_splitter_ipa_if.slave (cmd / queue read / row request)
//   busy_o        : FSM not IDLE
//   err_o         : only with TWD_SPLIT_ERR_EN defined; sticky flag for a 2D
//                   command carrying row_len==0 (the command is dropped)
// Optional feature macro: TWD_SPLIT_ERR_EN
module twd_trans_splitter_ipa
  import mchan_twd_pkg_ipa::*;
#(
  parameter int ADD_WIDTH           = ADD_WIDTH_DEF,
  parameter int LEN_WIDTH           = LEN_WIDTH_DEF,
  parameter int ROWLEN_WIDTH        = ROWLEN_WIDTH_DEF,
  parameter int STRIDE_WIDTH        = STRIDE_WIDTH_DEF,
  parameter int TWD_QUEUE_ADD_WIDTH = TWD_QUEUE_ADD_WIDTH_DEF,
  parameter int TWD_QUEUE_WIDTH     = STRIDE_WIDTH + ROWLEN_WIDTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  twd_trans_splitter_ipa_if.slave bus,
  output logic busy_o
`ifdef TWD_SPLIT_ERR_EN
  ,
  output logic err_o
`endif
);

  function automatic logic [LEN_WIDTH-1:0] chunk_of(input logic [LEN_WIDTH-1:0] rem,
                                                    input logic [LEN_WIDTH-1:0] row);
    return (rem < row) ? rem : row;
  endfunction

  split_state_e            state_q;
  logic [ADD_WIDTH-1:0]    ext_q, tcdm_q;
  logic [LEN_WIDTH-1:0]    rem_q, row_q;
  logic [STRIDE_WIDTH-1:0] stride_q;
  logic                    opc_q;

  logic                    in_split, last, accept, row_zero, drop;
  logic [LEN_WIDTH-1:0]    chunk, ent_row, nxt_row;
  logic [STRIDE_WIDTH-1:0] ent_stride;
  logic [ADD_WIDTH-1:0]    stride_sx;

  assign in_split = (state_q == SPLIT);
  assign chunk    = chunk_of(rem_q, row_q);
  assign last     = (rem_q <= row_q);

  // Gnt also opens on the final row grant so a waiting command is taken
  // without an idle cycle between commands.
  assign bus.cmd_gnt_o = !in_split || (last && bus.out_gnt_i);
  assign accept        = bus.cmd_req_i && bus.cmd_gnt_o;

  assign bus.twd_rd_req_o = accept && bus.cmd_twd_i;
  assign bus.twd_rd_add_o = bus.twd_rd_req_o ? bus.cmd_twd_add_i : '0;

  assign ent_stride = bus.twd_rd_dat_i[TWD_QUEUE_WIDTH-1 -: STRIDE_WIDTH];
  assign ent_row    = LEN_WIDTH'(bus.twd_rd_dat_i[ROWLEN_WIDTH-1:0]);
  assign row_zero   = bus.cmd_twd_i && (ent_row == '0);
  // A zero row length would never make progress; fall back to one full-length row.
  assign nxt_row    = (bus.cmd_twd_i && !row_zero) ? ent_row : bus.cmd_len_i;

`ifdef TWD_SPLIT_ERR_EN
  assign drop = row_zero;
`else
  assign drop = 1'b0;
`endif

  assign stride_sx = {{(ADD_WIDTH-STRIDE_WIDTH){stride_q[STRIDE_WIDTH-1]}}, stride_q};

  // Length/last are masked in IDLE: stale registers would otherwise show last=1.
  assign bus.out_req_o      = in_split;
  assign bus.out_ext_add_o  = ext_q;
  assign bus.out_tcdm_add_o = tcdm_q;
  assign bus.out_opc_o      = opc_q;
  assign bus.out_len_o      = in_split ? chunk : '0;
  assign bus.out_last_o     = in_split && last;
  assign busy_o             = in_split;

`ifdef TWD_SPLIT_ERR_EN
  logic err_q;
  assign err_o = err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ext_q    <= '0;
      tcdm_q   <= '0;
      rem_q    <= '0;
      row_q    <= '0;
      stride_q <= '0;
      opc_q    <= 1'b0;
`ifdef TWD_SPLIT_ERR_EN
      err_q    <= 1'b0;
`endif
    end else if (accept) begin
      ext_q    <= bus.cmd_ext_add_i;
      tcdm_q   <= bus.cmd_tcdm_add_i;
      opc_q    <= bus.cmd_opc_i;
      rem_q    <= bus.cmd_len_i;
      row_q    <= nxt_row;
      stride_q <= bus.cmd_twd_i ? ent_stride : '0;
      state_q  <= ((bus.cmd_len_i != '0) && !drop) ? SPLIT : IDLE;
`ifdef TWD_SPLIT_ERR_EN
      err_q    <= err_q | drop;
`endif
    end else if (in_split && bus.out_gnt_i) begin
      ext_q  <= ext_q + stride_sx;
      tcdm_q <= tcdm_q + ADD_WIDTH'(chunk);
      rem_q  <= rem_q - chunk;
      if (last) state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_twd_trans_splitter_ipa.sv
module tb_twd_trans_splitter_ipa;
  import mchan_twd_pkg_ipa::*;

  typedef struct packed {
    logic [31:0] ext;
    logic [31:0] tcdm;
    logic [15:0] len;
    logic        last;
    logic        opc;
  } row_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic busy;
`ifdef TWD_SPLIT_ERR_EN
  logic err;
`endif

  always #5 clk_i = ~clk_i;

  twd_trans_splitter_ipa_if bus ();

  twd_trans_splitter_ipa dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus),
    .busy_o (busy)
`ifdef TWD_SPLIT_ERR_EN
    ,
    .err_o  (err)
`endif
  );

  twd_entry_t qmem [4];
  assign bus.twd_rd_dat_i = qmem[bus.twd_rd_add_o];

  int   total = 0;
  int   bad   = 0;
  int   stall_n = 0;
  row_t exp_q[$];
  logic [1:0] slot_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string nm, input row_t act, input row_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ext=%h tcdm=%h len=%0d last=%b opc=%b expected ext=%h tcdm=%h len=%0d last=%b opc=%b",
               nm, act.ext, act.tcdm, act.len, act.last, act.opc,
               exp.ext, exp.tcdm, exp.len, exp.last, exp.opc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic row_t mk(input logic [31:0] e, input logic [31:0] t, input logic [15:0] l,
                              input logic la, input logic o);
    row_t r;
    r.ext = e; r.tcdm = t; r.len = l; r.last = la; r.opc = o;
    return r;
  endfunction

  task automatic drive_cmd(input logic [31:0] e, input logic [31:0] t, input logic [15:0] l,
                           input logic o, input logic twd, input logic [1:0] slot);
    bus.cmd_ext_add_i  = e;
    bus.cmd_tcdm_add_i = t;
    bus.cmd_len_i      = l;
    bus.cmd_opc_i      = o;
    bus.cmd_twd_i      = twd;
    bus.cmd_twd_add_i  = slot;
    bus.cmd_req_i      = 1'b1;
  endtask

  task automatic wait_accept(input string nm);
    int n = 0;
    @(negedge clk_i);
    while (!bus.cmd_gnt_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 50) fail_now({nm, "_accept_timeout"});
    @(posedge clk_i);
    #1 bus.cmd_req_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    if (n >= 200) fail_now({nm, "_idle_timeout"});
    @(posedge clk_i);
    #1;
  endtask

  // Row consumer: grant always, or hold gnt low stall_n cycles per row.
  initial begin
    int w = 0;
    bus.out_gnt_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (stall_n == 0) begin
        bus.out_gnt_i = 1'b1; w = 0;
      end else if (bus.out_req_o && w < stall_n) begin
        bus.out_gnt_i = 1'b0; w++;
      end else begin
        bus.out_gnt_i = 1'b1; w = 0;
      end
    end
  end

  // Monitor: queue reads, granted rows, and field stability under backpressure.
  initial begin
    row_t cur, snap;
    logic stalled = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stalled = 1'b0;
      end else begin
        cur = mk(bus.out_ext_add_o, bus.out_tcdm_add_o, bus.out_len_o, bus.out_last_o, bus.out_opc_o);
        if (bus.twd_rd_req_o) begin
          if (slot_q.size() == 0) fail_now("twd_rd_unexpected");
          else chk("twd_rd_add", 64'(bus.twd_rd_add_o), 64'(slot_q.pop_front()));
        end
        if (bus.out_req_o) begin
          if (stalled) chk_row("stall_hold", cur, snap);
          if (bus.out_gnt_i) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) fail_now("row_unexpected");
            else chk_row("row", cur, exp_q.pop_front());
          end else begin
            stalled = 1'b1;
            snap = cur;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_req_i = 1'b0;
    drive_cmd(32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 2'd0);
    bus.cmd_req_i = 1'b0;
    qmem[0] = '{stride: 16'hFFC0, row_len: 16'd16};
    qmem[1] = '{stride: 16'h0100, row_len: 16'd16};
    qmem[2] = '{stride: 16'h0100, row_len: 16'd16};
    qmem[3] = '{stride: 16'h0100, row_len: 16'd0};

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_cmd_gnt", 64'(bus.cmd_gnt_o), 64'd1);
    chk("rst_out_req", 64'(bus.out_req_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_twd_rd_req", 64'(bus.twd_rd_req_o), 64'd0);
    chk("rst_out_ext", 64'(bus.out_ext_add_o), 64'd0);
    chk("rst_out_len", 64'(bus.out_len_o), 64'd0);
    chk("rst_out_last", 64'(bus.out_last_o), 64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // 1D command: single row one cycle after acceptance
    exp_q.push_back(mk(32'h1000, 32'h200, 16'd64, 1'b1, 1'b1));
    drive_cmd(32'h1000, 32'h200, 16'd64, 1'b1, 1'b0, 2'd0);
    wait_accept("t1");
    @(negedge clk_i);
    chk("t1_latency", 64'(bus.out_req_o), 64'd1);
    wait_idle("t1");

    // 2D: three full rows
    slot_q.push_back(2'd2);
    exp_q.push_back(mk(32'h1000, 32'h200, 16'd16, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h1100, 32'h210, 16'd16, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h1200, 32'h220, 16'd16, 1'b1, 1'b0));
    drive_cmd(32'h1000, 32'h200, 16'd48, 1'b0, 1'b1, 2'd2);
    wait_accept("t2");
    wait_idle("t2");

    // 2D short tail
    slot_q.push_back(2'd1);
    exp_q.push_back(mk(32'h2000, 32'h300, 16'd16, 1'b0, 1'b1));
    exp_q.push_back(mk(32'h2100, 32'h310, 16'd16, 1'b0, 1'b1));
    exp_q.push_back(mk(32'h2200, 32'h320, 16'd8,  1'b1, 1'b1));
    drive_cmd(32'h2000, 32'h300, 16'd40, 1'b1, 1'b1, 2'd1);
    wait_accept("t3");
    wait_idle("t3");

    // negative stride with backpressure
    stall_n = 3;
    slot_q.push_back(2'd0);
    exp_q.push_back(mk(32'h1000, 32'h200, 16'd16, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0FC0, 32'h210, 16'd16, 1'b1, 1'b0));
    drive_cmd(32'h1000, 32'h200, 16'd32, 1'b0, 1'b1, 2'd0);
    wait_accept("t4");
    wait_idle("t4");
    stall_n = 0;

    // external address wraps past 2^32
    slot_q.push_back(2'd1);
    exp_q.push_back(mk(32'hFFFF_FF80, 32'h400, 16'd16, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0000_0080, 32'h410, 16'd16, 1'b1, 1'b0));
    drive_cmd(32'hFFFF_FF80, 32'h400, 16'd32, 1'b0, 1'b1, 2'd1);
    wait_accept("t5");
    wait_idle("t5");

    // back-to-back: second command taken on the final row grant
    exp_q.push_back(mk(32'h3000, 32'h500, 16'd8, 1'b1, 1'b0));
    slot_q.push_back(2'd2);
    exp_q.push_back(mk(32'h4000, 32'h600, 16'd16, 1'b0, 1'b1));
    exp_q.push_back(mk(32'h4100, 32'h610, 16'd16, 1'b1, 1'b1));
    drive_cmd(32'h3000, 32'h500, 16'd8, 1'b0, 1'b0, 2'd0);
    wait_accept("t6a");
    drive_cmd(32'h4000, 32'h600, 16'd32, 1'b1, 1'b1, 2'd2);
    @(negedge clk_i);
    chk("b2b_last", 64'(bus.out_last_o), 64'd1);
    chk("b2b_cmd_gnt", 64'(bus.cmd_gnt_o), 64'd1);
    @(posedge clk_i);
    #1 bus.cmd_req_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_next_req", 64'(bus.out_req_o), 64'd1);
    chk("b2b_next_ext", 64'(bus.out_ext_add_o), 64'h4000);
    wait_idle("t6");

    // len=0 2D: slot released, no rows
    slot_q.push_back(2'd2);
    drive_cmd(32'h7000, 32'h900, 16'd0, 1'b0, 1'b1, 2'd2);
    wait_accept("t7");
    @(negedge clk_i);
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_out_req", 64'(bus.out_req_o), 64'd0);
    wait_idle("t7");

    // row_len=0 on a 2D command
    slot_q.push_back(2'd3);
`ifndef TWD_SPLIT_ERR_EN
    exp_q.push_back(mk(32'h5000, 32'h700, 16'd24, 1'b1, 1'b0));
`endif
    drive_cmd(32'h5000, 32'h700, 16'd24, 1'b0, 1'b1, 2'd3);
    wait_accept("t8");
    wait_idle("t8");
`ifdef TWD_SPLIT_ERR_EN
    chk("rowlen0_err", 64'(err), 64'd1);
    chk("rowlen0_busy", 64'(busy), 64'd0);
`endif

    // reset in the middle of a stalled SPLIT
    stall_n = 3;
    slot_q.push_back(2'd2);
    drive_cmd(32'h1000, 32'h200, 16'd48, 1'b0, 1'b1, 2'd2);
    wait_accept("t9");
    @(negedge clk_i);
    chk("t9_in_split", 64'(bus.out_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst_out_req", 64'(bus.out_req_o), 64'd0);
    chk("mrst_cmd_gnt", 64'(bus.cmd_gnt_o), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_out_ext", 64'(bus.out_ext_add_o), 64'd0);
    chk("mrst_out_tcdm", 64'(bus.out_tcdm_add_o), 64'd0);
    chk("mrst_out_len", 64'(bus.out_len_o), 64'd0);
    chk("mrst_out_last", 64'(bus.out_last_o), 64'd0);
`ifdef TWD_SPLIT_ERR_EN
    chk("mrst_err", 64'(err), 64'd0);
`endif
    stall_n = 0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // recovery after reset
    exp_q.push_back(mk(32'h6000, 32'h800, 16'd4, 1'b1, 1'b1));
    drive_cmd(32'h6000, 32'h800, 16'd4, 1'b1, 1'b0, 2'd0);
    wait_accept("t10");
    wait_idle("t10");

    chk("rows_left", 64'(exp_q.size()), 64'd0);
    chk("slots_left", 64'(slot_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
